// File: rtl/axi_lite_alu_pkg.sv
// Shared constants and types for the AXI-Lite ALU: register offsets, opcodes,
// response codes, STATUS bit positions and FSM state encodings.
package axi_lite_alu_pkg;

  localparam logic [7:0] OFF_CTRL   = 8'h00;
  localparam logic [7:0] OFF_OPA    = 8'h04;
  localparam logic [7:0] OFF_OPB    = 8'h08;
  localparam logic [7:0] OFF_RESULT = 8'h0C;
  localparam logic [7:0] OFF_STATUS = 8'h10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int CTRL_START = 0;
  localparam int ST_DONE    = 0;
  localparam int ST_CARRY   = 1;
  localparam int ST_OVF     = 2;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_ACC = 2'b10,
    OP_CLR = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    SEL_CTRL, SEL_OPA, SEL_OPB, SEL_RESULT, SEL_STATUS, SEL_NONE
  } reg_sel_e;

  typedef enum logic { W_IDLE, W_RESP } wr_state_e;
  typedef enum logic { R_IDLE, R_DATA } rd_state_e;

endpackage

// File: rtl/axi_lite_alu_core.sv
// Arithmetic core: holds RESULT and updates it on a start pulse, emitting
// DONE/CARRY/OVF set pulses in the same cycle the update is committed.
module axi_lite_alu_core
  import axi_lite_alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  op_e                   op,
  input  logic [DATA_WIDTH-1:0] opa,
  input  logic [DATA_WIDTH-1:0] opb,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  done_set,
  output logic                  carry_set,
  output logic                  ovf_set
);

  localparam int MSB = DATA_WIDTH - 1;

  logic [DATA_WIDTH:0] wide;
  logic                ovf;

  // The extra top bit of 'wide' is carry-out for add/acc and borrow for sub.
  always_comb begin
    wide = '0;
    ovf  = 1'b0;
    case (op)
      OP_ADD: begin
        wide = {1'b0, opa} + {1'b0, opb};
        ovf  = (opa[MSB] == opb[MSB]) && (wide[MSB] != opa[MSB]);
      end
      OP_SUB: begin
        wide = {1'b0, opa} - {1'b0, opb};
        ovf  = (opa[MSB] != opb[MSB]) && (wide[MSB] != opa[MSB]);
      end
      OP_ACC: begin
        wide = {1'b0, result} + {1'b0, opa};
        ovf  = (result[MSB] == opa[MSB]) && (wide[MSB] != result[MSB]);
      end
      default: wide = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)        result <= '0;
    else if (start) result <= wide[DATA_WIDTH-1:0];
  end

  assign done_set  = start;
  assign carry_set = start & wide[DATA_WIDTH];
  assign ovf_set   = start & ovf;

endmodule

// File: rtl/axi_lite_alu.sv
// AXI4-Lite slave exposing a small ALU: CTRL/OPA/OPB/RESULT/STATUS registers,
// independent single-outstanding write and read channels.
module axi_lite_alu
  import axi_lite_alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                    s1_axi_aclk,
  input  logic                    s1_axi_areset,
  input  logic [ADDR_WIDTH-1:0]   s1_axi_awaddr,
  input  logic                    s1_axi_awvalid,
  output logic                    s1_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s1_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s1_axi_wstrb,
  input  logic                    s1_axi_wvalid,
  output logic                    s1_axi_wready,
  output logic [1:0]              s1_axi_bresp,
  output logic                    s1_axi_bvalid,
  input  logic                    s1_axi_bready,
  input  logic [ADDR_WIDTH-1:0]   s1_axi_araddr,
  input  logic                    s1_axi_arvalid,
  output logic                    s1_axi_arready,
  output logic [DATA_WIDTH-1:0]   s1_axi_rdata,
  output logic [1:0]              s1_axi_rresp,
  output logic                    s1_axi_rvalid,
  input  logic                    s1_axi_rready
);

  localparam int NB = DATA_WIDTH / 8;

  wire clk = s1_axi_aclk;
  wire rst = s1_axi_areset;

  wr_state_e             wstate;
  rd_state_e             rstate;
  logic [DATA_WIDTH-1:0] ctrl, opa, opb, result;
  logic [2:0]            status, st_set, st_clr;
  logic                  start_q, done_set, carry_set, ovf_set;
  reg_sel_e              wr_sel, rd_sel;
  logic                  wr_fire, wr_err;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [1:0]            rd_resp;

  function automatic reg_sel_e decode(input logic [ADDR_WIDTH-1:0] a);
    if      (a == ADDR_WIDTH'(OFF_CTRL))   return SEL_CTRL;
    else if (a == ADDR_WIDTH'(OFF_OPA))    return SEL_OPA;
    else if (a == ADDR_WIDTH'(OFF_OPB))    return SEL_OPB;
    else if (a == ADDR_WIDTH'(OFF_RESULT)) return SEL_RESULT;
    else if (a == ADDR_WIDTH'(OFF_STATUS)) return SEL_STATUS;
    else                                   return SEL_NONE;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] merge(input logic [DATA_WIDTH-1:0] old,
                                                  input logic [DATA_WIDTH-1:0] d,
                                                  input logic [NB-1:0]         s);
    merge = old;
    for (int i = 0; i < NB; i++)
      if (s[i]) merge[i*8 +: 8] = d[i*8 +: 8];
  endfunction

  assign wr_sel  = decode(s1_axi_awaddr);
  assign rd_sel  = decode(s1_axi_araddr);
  assign wr_fire = s1_axi_awready && s1_axi_awvalid && s1_axi_wvalid;
  assign wr_err  = (wr_sel == SEL_RESULT) || (wr_sel == SEL_NONE);

  // Write channel: ready pulses only once both address and data are presented.
  always_ff @(posedge clk) begin
    if (rst) begin
      wstate         <= W_IDLE;
      s1_axi_awready <= 1'b0;
      s1_axi_wready  <= 1'b0;
      s1_axi_bvalid  <= 1'b0;
      s1_axi_bresp   <= RESP_OKAY;
    end else begin
      case (wstate)
        W_IDLE:
          if (s1_axi_awready) begin
            s1_axi_awready <= 1'b0;
            s1_axi_wready  <= 1'b0;
            if (wr_fire) begin
              s1_axi_bvalid <= 1'b1;
              s1_axi_bresp  <= wr_err ? RESP_SLVERR : RESP_OKAY;
              wstate        <= W_RESP;
            end
          end else if (s1_axi_awvalid && s1_axi_wvalid) begin
            s1_axi_awready <= 1'b1;
            s1_axi_wready  <= 1'b1;
          end
        W_RESP:
          if (s1_axi_bready) begin
            s1_axi_bvalid <= 1'b0;
            wstate        <= W_IDLE;
          end
      endcase
    end
  end

  always_comb begin
    st_clr = '0;
    if (wr_fire && wr_sel == SEL_STATUS && s1_axi_wstrb[0]) st_clr = s1_axi_wdata[2:0];
    st_set           = '0;
    st_set[ST_DONE]  = done_set;
    st_set[ST_CARRY] = carry_set;
    st_set[ST_OVF]   = ovf_set;
  end

  // START is not stored: CTRL bit0 always reads back as zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl    <= '0;
      opa     <= '0;
      opb     <= '0;
      status  <= '0;
      start_q <= 1'b0;
    end else begin
      start_q <= wr_fire && (wr_sel == SEL_CTRL) && s1_axi_wstrb[0] && s1_axi_wdata[CTRL_START];
      if (wr_fire) begin
        case (wr_sel)
          SEL_CTRL: begin
            ctrl             <= merge(ctrl, s1_axi_wdata, s1_axi_wstrb);
            ctrl[CTRL_START] <= 1'b0;
          end
          SEL_OPA: opa <= merge(opa, s1_axi_wdata, s1_axi_wstrb);
          SEL_OPB: opb <= merge(opb, s1_axi_wdata, s1_axi_wstrb);
          default: ;
        endcase
      end
      // A flag being set in the same cycle as its W1C clear stays set.
      status <= (status & ~st_clr) | st_set;
    end
  end

  axi_lite_alu_core #(.DATA_WIDTH(DATA_WIDTH)) u_core (
    .clk       (clk),
    .rst       (rst),
    .start     (start_q),
    .op        (op_e'(ctrl[2:1])),
    .opa       (opa),
    .opb       (opb),
    .result    (result),
    .done_set  (done_set),
    .carry_set (carry_set),
    .ovf_set   (ovf_set)
  );

  always_comb begin
    rd_data = '0;
    rd_resp = RESP_OKAY;
    case (rd_sel)
      SEL_CTRL:   rd_data = ctrl;
      SEL_OPA:    rd_data = opa;
      SEL_OPB:    rd_data = opb;
      SEL_RESULT: rd_data = result;
      SEL_STATUS: rd_data = {{(DATA_WIDTH-3){1'b0}}, status};
      default:    rd_resp = RESP_SLVERR;
    endcase
  end

  // Read data is sampled at the address handshake, so a concurrent RESULT
  // update is seen only by the next read.
  always_ff @(posedge clk) begin
    if (rst) begin
      rstate         <= R_IDLE;
      s1_axi_arready <= 1'b0;
      s1_axi_rvalid  <= 1'b0;
      s1_axi_rdata   <= '0;
      s1_axi_rresp   <= RESP_OKAY;
    end else begin
      case (rstate)
        R_IDLE:
          if (s1_axi_arready) begin
            s1_axi_arready <= 1'b0;
            if (s1_axi_arvalid) begin
              s1_axi_rdata  <= rd_data;
              s1_axi_rresp  <= rd_resp;
              s1_axi_rvalid <= 1'b1;
              rstate        <= R_DATA;
            end
          end else if (s1_axi_arvalid) begin
            s1_axi_arready <= 1'b1;
          end
        R_DATA:
          if (s1_axi_rready) begin
            s1_axi_rvalid <= 1'b0;
            rstate        <= R_IDLE;
          end
      endcase
    end
  end

endmodule
